// File: rtl/pts_tx_24_lsb.sv
// Parallel-to-serial transmitter: valid/ready intake into a one-word holding buffer,
// LSB-first shift-out with a per-bit strobe that drives the paired receiver's shift enable.
module pts_tx_24_lsb #(
   parameter int WIDTH        = 24,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             serial_out,
   output logic             shift_strobe,
   output logic             busy,
   output logic             tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] hold_reg;
   logic             hold_full;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] load_word;
   logic [CW-1:0]    clk_cnt;
   logic [BW-1:0]    bit_cnt;
   logic             bit_end;
   logic             frame_end;
   logic             accept;
   logic             load;

   // NOTE: every signal gets a value before any branch, so no path can infer a latch.
   always_comb begin
      bit_end    = (state == SHIFT) && (clk_cnt == CLK_LAST);
      frame_end  = bit_end && (bit_cnt == BIT_LAST);
      accept     = tx_valid && !hold_full;
      load       = ((state == IDLE) || frame_end) && (hold_full || accept);
      // Buffered word always goes first; otherwise the incoming word bypasses the buffer.
      load_word  = hold_full ? hold_reg : tx_data;
      state_next = state;
      if (load) begin
         state_next = SHIFT;
      end else if (frame_end) begin
         state_next = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: the data registers are reset too; they are few, and it keeps simulation X-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_reg  <= '0;
         hold_full <= 1'b0;
         shift_reg <= '0;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= frame_end;

         // An accept is impossible while the buffer is full, so the two branches never overlap.
         if (load && hold_full) begin
            hold_full <= 1'b0;
         end else if (accept && !load) begin
            hold_reg  <= tx_data;
            hold_full <= 1'b1;
         end

         if (load) begin
            shift_reg <= load_word;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
         end else if (frame_end) begin
            shift_reg <= '0;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
         end else if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            clk_cnt   <= '0;
            bit_cnt   <= bit_cnt + 1'b1;
         end else if (state == SHIFT) begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end

   assign tx_ready     = !hold_full;
   assign busy         = (state == SHIFT);
   assign serial_out   = busy && shift_reg[0];
   assign shift_strobe = bit_end;

endmodule

// File: tb/tb_pts_tx_24_lsb.sv
// Self-checking bench for pts_tx_24_lsb: one instance at 1 clock/bit, one at 4 clocks/bit,
// with a behavioural LSB-first receiver model shifting on shift_strobe.
module tb_pts_tx_24_lsb;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] tx_data;
   logic        tx_valid;
   logic [1:0]  en;

   logic ready1, ser1, str1, busy1, done1;
   logic ready4, ser4, str4, busy4, done4;
   logic o_ready, o_ser, o_strobe, o_busy, o_done;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pts_tx_24_lsb #(.WIDTH(24), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid && en[0]),
      .tx_ready(ready1), .serial_out(ser1), .shift_strobe(str1), .busy(busy1), .tx_done(done1)
   );

   pts_tx_24_lsb #(.WIDTH(24), .CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid && en[1]),
      .tx_ready(ready4), .serial_out(ser4), .shift_strobe(str4), .busy(busy4), .tx_done(done4)
   );

   assign o_ready  = en[1] ? ready4 : ready1;
   assign o_ser    = en[1] ? ser4   : ser1;
   assign o_strobe = en[1] ? str4   : str1;
   assign o_busy   = en[1] ? busy4  : busy1;
   assign o_done   = en[1] ? done4  : done1;

   typedef struct {
      logic        sel;          // 0: 1 clock/bit, 1: 4 clocks/bit
      logic [23:0] word;
      int          exp_strobes;
      int          exp_done_at;  // samples from accept to the tx_done sample
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one word from idle and follows it to tx_done, checking every bit on its strobe.
   task automatic run_frame(input logic sel, input logic [23:0] w, input int exp_strobes,
                            input int exp_done_at);
      int          cpb;
      int          strobes;
      int          bit_i;
      int          done_at;
      int          stray;
      logic [23:0] rx;
      cpb     = sel ? 4 : 1;
      en      = sel ? 2'b10 : 2'b01;
      strobes = 0;
      bit_i   = 0;
      done_at = 0;
      stray   = 0;
      rx      = '0;
      tx_data  = w;
      tx_valid = 1'b1;
      #1;
      check("frame_ready_idle", o_ready, 1'b1);
      step();
      tx_valid = 1'b0;
      check("frame_latency_busy", o_busy, 1'b1);
      check("frame_latency_bit0", o_ser, w[0]);
      for (int c = 1; c <= 24 * cpb + 4; c++) begin
         if (o_done) begin
            done_at = c;
            check("frame_idle_after_done", o_busy, 1'b0);
            break;
         end
         if (o_strobe) begin
            if (bit_i < 24) check("frame_bit", o_ser, w[bit_i]);
            if (c % cpb != 0) stray++;
            rx = {o_ser, rx[23:1]};
            bit_i++;
            strobes++;
         end
         step();
      end
      check("frame_done_at", done_at, exp_done_at);
      check("frame_strobes", strobes, exp_strobes);
      check("frame_stray_strobes", stray, 0);
      check("frame_rx_word", rx, w);
   endtask

   logic [23:0] words[3];
   logic [23:0] sb[$];
   logic [23:0] rx;
   logic        acc;
   int          idx, n_done, n_str, first_s, last_s, prev_done, ready_low, n_hs, quiet;

   initial begin
      vecs[0] = '{1'b0, 24'hA5C3F0, 24, 25};
      vecs[1] = '{1'b1, 24'h123456, 24, 97};
      vecs[2] = '{1'b0, 24'h000000, 24, 25};
      vecs[3] = '{1'b0, 24'hFFFFFF, 24, 25};
      vecs[4] = '{1'b1, 24'h800001, 24, 97};
      vecs[5] = '{1'b0, 24'h5A5A5A, 24, 25};

      // Reset with tx_valid high on both instances.
      en       = 2'b11;
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 24'hDEADBE;
      step();
      step();
      check("rst_ser1", ser1, 1'b0);
      check("rst_str1", str1, 1'b0);
      check("rst_busy1", busy1, 1'b0);
      check("rst_done1", done1, 1'b0);
      check("rst_ready1", ready1, 1'b1);
      check("rst_ser4", ser4, 1'b0);
      check("rst_str4", str4, 1'b0);
      check("rst_busy4", busy4, 1'b0);
      check("rst_done4", done4, 1'b0);
      check("rst_ready4", ready4, 1'b1);
      rst      = 1'b0;
      tx_valid = 1'b0;
      step();
      check("rst_no_accept_busy1", busy1, 1'b0);
      check("rst_no_accept_busy4", busy4, 1'b0);
      check("rst_no_strobe_after", str1, 1'b0);
      check("rst_buffer_empty", ready1 && ready4, 1'b1);

      // Single-word table.
      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].sel, vecs[i].word, vecs[i].exp_strobes, vecs[i].exp_done_at);
         step();
      end

      // Back-to-back stream, tx_valid held high.
      en        = 2'b01;
      words[0]  = 24'h000001;
      words[1]  = 24'h800000;
      words[2]  = 24'hFFFFFF;
      idx       = 0;
      tx_data   = words[0];
      tx_valid  = 1'b1;
      n_done    = 0;
      n_str     = 0;
      first_s   = -1;
      last_s    = -1;
      prev_done = -1;
      ready_low = 0;
      rx        = '0;
      #1;
      for (int c = 0; c < 120 && n_done < 3; c++) begin
         acc = tx_valid && o_ready;
         step();
         if (acc) begin
            idx++;
            if (idx < 3) tx_data = words[idx];
            else tx_valid = 1'b0;
         end
         if (!o_ready) ready_low++;
         if (o_done) begin
            check("b2b_rx_word", rx, words[n_done]);
            check("b2b_busy_at_done", o_busy, (n_done < 2) ? 1'b1 : 1'b0);
            if (prev_done >= 0) check("b2b_done_spacing", c - prev_done, 24);
            prev_done = c;
            n_done++;
         end
         if (o_strobe) begin
            if (first_s < 0) first_s = c;
            last_s = c;
            n_str++;
            rx = {o_ser, rx[23:1]};
         end
      end
      check("b2b_done_count", n_done, 3);
      check("b2b_strobes", n_str, 72);
      check("b2b_strobe_span", last_s - first_s + 1, 72);
      check("b2b_ready_low_cycles", ready_low, 46);
      step();

      // Reset at bit 10 with the buffer full.
      tx_data  = 24'h3C3C3C;
      tx_valid = 1'b1;
      step();
      tx_data = 24'hC3C3C3;
      step();
      tx_valid = 1'b0;
      check("midrst_buffer_full", o_ready, 1'b0);
      for (int i = 0; i < 9; i++) step();
      check("midrst_busy_before", o_busy, 1'b1);
      rst = 1'b1;
      step();
      check("midrst_busy", o_busy, 1'b0);
      check("midrst_ready", o_ready, 1'b1);
      check("midrst_done", o_done, 1'b0);
      check("midrst_ser", o_ser, 1'b0);
      check("midrst_strobe", o_strobe, 1'b0);
      rst   = 1'b0;
      quiet = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (o_done || o_strobe || o_busy) quiet++;
      end
      check("midrst_no_activity", quiet, 0);
      run_frame(1'b0, 24'h0F0F0F, 24, 25);
      step();

      // Backpressure on the 4 clock/bit instance: scoreboard of accepted words.
      en       = 2'b10;
      tx_valid = 1'b0;
      n_hs     = 0;
      n_done   = 0;
      rx       = '0;
      #1;
      for (int c = 0; c < 1200; c++) begin
         if (o_done) begin
            if (sb.size() == 0) check("bp_extra_frame", 1'b1, 1'b0);
            else check("bp_rx_word", rx, sb.pop_front());
            n_done++;
         end
         if (o_strobe) rx = {o_ser, rx[23:1]};
         if (c >= 250 && sb.size() == 0 && !o_busy) break;
         if (c < 250) begin
            if (c % 2 == 1) begin
               tx_valid = 1'b0;
               tx_data  = 24'($urandom);
            end else begin
               tx_valid = 1'b1;
            end
         end else begin
            tx_valid = 1'b0;
         end
         if (tx_valid && o_ready) begin
            sb.push_back(tx_data);
            n_hs++;
         end
         step();
      end
      check("bp_frames_eq_handshakes", n_done, n_hs);
      check("bp_scoreboard_drained", sb.size(), 0);
      check("bp_handshakes_seen", n_hs >= 3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
